// File: rtl/control_unit_state.sv
// control_unit_state: next-state sequencer for the multi-cycle MIPS core.
// Holds the 4-bit control state, advances it from the opcode and the memory
// ready handshake, flags unsupported opcodes and counts retired instructions.
module control_unit_state #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic [3:0]       curState,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    // Encoding is shared with the control-signal decoder, so values are fixed.
    typedef enum logic [3:0] {
        IDLE            = 4'b0000,
        FETCH           = 4'b0001,
        DECODE          = 4'b0010,
        MEM_ADDRESS     = 4'b0011,
        MEM_READ        = 4'b0100,
        MEM_WRITE_BACK  = 4'b0101,
        MEM_WRITE       = 4'b0110,
        EXECUTE         = 4'b0111,
        ALU_WRITE_BACK  = 4'b1000,
        BRANCH          = 4'b1001,
        ADDI_EXECUTE    = 4'b1010,
        ADDI_WRITE_BACK = 4'b1011,
        JUMP            = 4'b1100,
        SUSPEND         = 4'b1101
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    stateT            state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] retireCnt_q, retireCnt_d;
    logic             finish;

    // Next-state logic; a terminal state raises finish, which retires the
    // instruction and decides between the next fetch and parking in idle.
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        finish      = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && !illegal_q) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = mem_ready ? DECODE : SUSPEND;
            end
            SUSPEND: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDRESS;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDI_EXECUTE;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = IDLE;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDRESS: begin
                state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                if (mem_ready) begin
                    state_d = MEM_WRITE_BACK;
                end
            end
            MEM_WRITE: begin
                if (mem_ready) begin
                    finish = 1'b1;
                end
            end
            EXECUTE:      state_d = ALU_WRITE_BACK;
            ADDI_EXECUTE: state_d = ADDI_WRITE_BACK;
            MEM_WRITE_BACK, ALU_WRITE_BACK, BRANCH, ADDI_WRITE_BACK, JUMP: begin
                finish = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (finish) begin
            state_d = run ? FETCH : IDLE;
        end
        retire_d    = finish;
        retireCnt_d = retireCnt_q + {{(CNT_W-1){1'b0}}, finish};
    end

    // State, sticky illegal flag, retire pulse and counter; reset wins always.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            illegal_q   <= 1'b0;
            retire_q    <= 1'b0;
            retireCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            retire_q    <= retire_d;
            retireCnt_q <= retireCnt_d;
        end
    end

    assign curState   = state_q;
    assign illegal    = illegal_q;
    assign retire     = retire_q;
    assign retire_cnt = retireCnt_q;

endmodule

// File: doc/control_unit_state.md
# control_unit_state

Next-state sequencer for the multi-cycle MIPS core. Holds the 4-bit control state register and advances it from the instruction opcode and memory-ready handshake. Its `curState` output drives the control-signal decoder, which turns each state into datapath strobes. Also flags illegal opcodes and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; permits leaving idle and continuing after each instruction.
- `opcode`  in  6  IR[31:26]; valid from decode onward and stable until the next fetch.
- `mem_ready`  in  1  unified memory has completed the current access this cycle.
- `curState`  out  4  registered control state, using the encoding below.
- `illegal`  out  1  sticky; set on an unsupported opcode; cleared only by `rst`.
- `retire`  out  1  registered one-cycle pulse when an instruction completes.
- `retire_cnt`  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

## Operation
State encoding (fixed, shared with the decoder):
- idle 0000, fetch 0001, decode 0010, memAddress 0011.
- memRead 0100, memWriteBack 0101, memWrite 0110.
- execute 0111, ALUWriteBack 1000, branch 1001.
- addiExecute 1010, addiWriteBack 1011, jump 1100, suspend 1101.
- Codes 1110 and 1111 are unused.

Transitions:
- idle: to fetch if `run`=1, else stay.
- fetch: to decode if `mem_ready`=1, else to suspend.
- suspend: stay while `mem_ready`=0; to decode when it is 1. PC is not re-incremented; the IR latch repeats.
- decode, by opcode:
  - 000000 (R-type): execute.
  - 100011 (lw) and 101011 (sw): memAddress.
  - 000100 (beq): branch.
  - 001000 (addi): addiExecute.
  - 000010 (j): jump.
  - Any other opcode: idle, and set `illegal`.
- memAddress: to memRead for lw, to memWrite for sw.
- memRead: stay while `mem_ready`=0; then memWriteBack.
- memWrite: stay while `mem_ready`=0; then it is a terminal state.
- execute: to ALUWriteBack. addiExecute: to addiWriteBack.
- Terminal states are memWriteBack, memWrite (with `mem_ready`=1), ALUWriteBack, branch, addiWriteBack and jump. From a terminal state, go to fetch if `run`=1, else to idle. Either way, `retire` pulses and `retire_cnt` increments.
- Unused codes 1110 and 1111 recover to idle on the next edge and do not set `illegal`.
- While `illegal`=1, idle ignores `run` (the core is halted until reset).

## Timing
- Reset values: `curState`=idle, `illegal`=0, `retire`=0, `retire_cnt`=0. Reset takes priority over every other input, including in the middle of an instruction; it takes effect on the next edge.
- `curState` is registered. The decoder sees a new state one cycle after the edge that produced it.
- `retire` is high during the cycle after the terminal state. `retire_cnt` updates on the same edge.
- Fetch-to-fetch latency with `mem_ready` held at 1:
  - R-type, sw, addi: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
- Each cycle `mem_ready` is low in fetch, memRead or memWrite adds exactly one cycle.
- `run` is sampled only in idle and in terminal states. Dropping it mid-instruction completes the instruction, then parks in idle.
- When `retire_cnt` is all-ones, the next retire wraps it to 0; `retire` still pulses.

## Test plan
- Reset, then `run`=1, opcode 000000, `mem_ready`=1 -> states 0,1,2,7,8,1. `retire` pulses once; `retire_cnt`=1.
- lw (100011) with `mem_ready` low for 2 cycles in memRead -> states 1,2,3,4,4,4,5,1. Fetch-to-fetch is 7 cycles.
- Fetch with `mem_ready`=0 for 3 cycles -> states 1,13,13,13,2. `retire` is not asserted during the wait.
- Opcode 111111 in decode -> idle next cycle, `illegal`=1, and it stays in idle despite `run`=1. Asserting `rst` clears `illegal` and `retire_cnt`.
- `run` dropped during execute of an R-type instruction -> ALUWriteBack, then idle, with `retire`=1 once. Raising `run` again -> fetch.
- `CNT_W`=4, 16 back-to-back j instructions -> `retire_cnt` wraps from 15 to 0; 3-cycle cadence throughout.
